// File: rtl/step_controller.sv
// Single-step / free-run clock-enable generator for a microcoded control unit.
// Debounced manual stepping, divided free-run strobe and a sticky halt.
module step_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned RATE_DIV        = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       run_mode,
  input  logic       step_btn,
  input  logic       halt,
  output logic       ctrl_en,
  output logic       halted,
  output logic [7:0] pulse_count
);

  typedef enum logic [1:0] {
    IDLE_STEP = 2'd0,
    FREE_RUN  = 2'd1,
    HALTED    = 2'd2
  } state_e;

  localparam logic [7:0] DB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] DIV_LAST = 8'(RATE_DIV - 1);

  logic       mode_meta_q, mode_sync_q;
  logic       btn_meta_q, btn_sync_q;
  logic       btn_db_q, btn_db_d;
  logic       btn_db_prev_q;
  logic [7:0] db_cnt_q, db_cnt_d;
  logic [7:0] div_q, div_d;
  state_e     state_q, state_d;
  logic       ctrl_en_q, ctrl_en_d;
  logic       halted_q, halted_d;
  logic [7:0] pcnt_q, pcnt_d;
  logic       step_evt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mode_meta_q   <= 1'b0;
      mode_sync_q   <= 1'b0;
      btn_meta_q    <= 1'b0;
      btn_sync_q    <= 1'b0;
      btn_db_q      <= 1'b0;
      btn_db_prev_q <= 1'b0;
      db_cnt_q      <= 8'd0;
      div_q         <= 8'd0;
      state_q       <= IDLE_STEP;
      ctrl_en_q     <= 1'b0;
      halted_q      <= 1'b0;
      pcnt_q        <= 8'd0;
    end else begin
      mode_meta_q   <= run_mode;
      mode_sync_q   <= mode_meta_q;
      btn_meta_q    <= step_btn;
      btn_sync_q    <= btn_meta_q;
      btn_db_q      <= btn_db_d;
      btn_db_prev_q <= btn_db_q;
      db_cnt_q      <= db_cnt_d;
      div_q         <= div_d;
      state_q       <= state_d;
      ctrl_en_q     <= ctrl_en_d;
      halted_q      <= halted_d;
      pcnt_q        <= pcnt_d;
    end
  end

  // A level change is accepted after DEBOUNCE_CYCLES consecutive mismatches.
  always_comb begin
    btn_db_d = btn_db_q;
    db_cnt_d = 8'd0;
    if (btn_sync_q != btn_db_q) begin
      if (db_cnt_q == DB_LAST) begin
        btn_db_d = btn_sync_q;
      end else begin
        db_cnt_d = db_cnt_q + 8'd1;
      end
    end
  end

  assign step_evt = btn_db_q & ~btn_db_prev_q;

  // Halt wins over everything; a mode change cancels divider and step alike.
  always_comb begin
    state_d   = state_q;
    div_d     = 8'd0;
    ctrl_en_d = 1'b0;
    halted_d  = halted_q;
    unique case (state_q)
      IDLE_STEP: begin
        if (halt) begin
          state_d  = HALTED;
          halted_d = 1'b1;
        end else if (mode_sync_q) begin
          state_d = FREE_RUN;
        end else begin
          ctrl_en_d = step_evt;
        end
      end
      FREE_RUN: begin
        if (halt) begin
          state_d  = HALTED;
          halted_d = 1'b1;
        end else if (!mode_sync_q) begin
          state_d = IDLE_STEP;
        end else if (div_q == DIV_LAST) begin
          ctrl_en_d = 1'b1;
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      HALTED: begin
        halted_d = 1'b1;
      end
      default: begin
        state_d = IDLE_STEP;
      end
    endcase
  end

  assign pcnt_d = pcnt_q + {7'd0, ctrl_en_q};

  assign ctrl_en     = ctrl_en_q;
  assign halted      = halted_q;
  assign pulse_count = pcnt_q;

endmodule

// File: tb/tb_step_controller.sv
// Randomized and directed bench for step_controller against a
// behavioural model built from run lengths and cycle counts.
module tb_step_controller;

  localparam int D = 4;
  localparam int R = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       run_mode = 1'b0;
  logic       step_btn = 1'b0;
  logic       halt = 1'b0;
  logic       ctrl_en, halted;
  logic [7:0] pulse_count;

  logic       run_f = 1'b0;
  logic       btn_f = 1'b0;
  logic       halt_f = 1'b0;
  logic       ctrl_en_f, halted_f;
  logic [7:0] pulse_count_f;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  step_controller #(.DEBOUNCE_CYCLES(D), .RATE_DIV(R)) u_dut (
    .CLK(CLK), .RST(RST), .run_mode(run_mode), .step_btn(step_btn),
    .halt(halt), .ctrl_en(ctrl_en), .halted(halted),
    .pulse_count(pulse_count)
  );

  step_controller #(.DEBOUNCE_CYCLES(D), .RATE_DIV(1)) u_fast (
    .CLK(CLK), .RST(RST), .run_mode(run_f), .step_btn(btn_f),
    .halt(halt_f), .ctrl_en(ctrl_en_f), .halted(halted_f),
    .pulse_count(pulse_count_f)
  );

  // Reference model: input delay lines, mismatch run length, and a count
  // of edges spent in free run since the mode was last seen to change.
  bit m_meta_b, m_sync_b, m_meta_m, m_sync_m;
  bit m_db, m_dbp, m_mode, m_halted, m_en;
  int m_run, m_k, m_cnt;

  function automatic void model_reset();
    m_meta_b = 0; m_sync_b = 0; m_meta_m = 0; m_sync_m = 0;
    m_db = 0; m_dbp = 0; m_mode = 0; m_halted = 0; m_en = 0;
    m_run = 0; m_k = 0; m_cnt = 0;
  endfunction

  function automatic void model_edge(input bit rm, input bit sb, input bit h);
    bit en_n;
    bit db_n;
    int run_n;
    db_n = m_db;
    run_n = 0;
    if (m_sync_b != m_db) begin
      run_n = m_run + 1;
      if (run_n >= D) begin
        db_n = m_sync_b;
        run_n = 0;
      end
    end
    en_n = 0;
    if (m_halted) begin
      en_n = 0;
    end else if (h) begin
      m_halted = 1;
    end else if (m_sync_m != m_mode) begin
      m_mode = m_sync_m;
      m_k = 0;
    end else if (m_mode) begin
      m_k = m_k + 1;
      en_n = (m_k % R) == 0;
    end else begin
      en_n = m_db && !m_dbp;
    end
    m_cnt = (m_cnt + int'(m_en)) % 256;
    m_en = en_n;
    m_dbp = m_db;
    m_db = db_n;
    m_run = run_n;
    m_sync_b = m_meta_b;
    m_meta_b = sb;
    m_sync_m = m_meta_m;
    m_meta_m = rm;
  endfunction

  // Called at a negedge; returns at the following negedge.
  task automatic cycle(input bit rm, input bit sb, input bit h);
    run_mode = rm;
    step_btn = sb;
    halt = h;
    @(posedge CLK);
    model_edge(rm, sb, h);
    @(negedge CLK);
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    RST = 1'b1;
    run_mode = 0; step_btn = 0; halt = 0;
    run_f = 0; halt_f = 0;
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_reset();
    #1 RST = 1'b1;
    #2;
    checks++;
    if ({ctrl_en, halted, pulse_count} !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs: got en=%b h=%b cnt=%0d want 0 0 0",
               ctrl_en, halted, pulse_count);
    end
    apply_reset();
  endtask

  task automatic test_step_latency();
    int first;
    first = -1;
    apply_reset();
    for (int i = 1; i <= 20; i++) begin
      cycle(0, 1, 0);
      checks++;
      if ({ctrl_en, halted, pulse_count} !== {m_en, m_halted, 8'(m_cnt)}) begin
        errors++;
        $display("FAIL step_model c%0d: got %b %b %0d want %b %b %0d",
                 i, ctrl_en, halted, pulse_count, m_en, m_halted, m_cnt);
      end
      if (ctrl_en === 1'b1 && first < 0) first = i;
    end
    checks++;
    if (first !== D + 3) begin
      errors++;
      $display("FAIL step_latency: pulse after edge %0d want %0d", first, D + 3);
    end
    checks++;
    if (pulse_count !== 8'd1) begin
      errors++;
      $display("FAIL step_count: got %0d want 1", pulse_count);
    end
    for (int i = 0; i < 12; i++) begin
      cycle(0, 0, 0);
      checks++;
      if (ctrl_en !== 1'b0) begin
        errors++;
        $display("FAIL release_no_pulse c%0d: got %b want 0", i, ctrl_en);
      end
    end
  endtask

  task automatic test_bounce();
    bit pat[4];
    int pulses;
    pat = '{1'b1, 1'b0, 1'b1, 1'b0};
    apply_reset();
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(0, (i < 4) ? pat[i] : 1'b1, 0);
      checks++;
      if ({ctrl_en, pulse_count} !== {m_en, 8'(m_cnt)}) begin
        errors++;
        $display("FAIL bounce_model c%0d: got %b %0d want %b %0d",
                 i, ctrl_en, pulse_count, m_en, m_cnt);
      end
      if (ctrl_en === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL bounce_pulses: got %0d want 1", pulses);
    end
    for (int i = 0; i < 12; i++) cycle(0, 0, 0);
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      cycle(0, (i < 3) ? 1'b1 : 1'b0, 0);
      if (ctrl_en === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL glitch_pulses: got %0d want 0", pulses);
    end
  endtask

  task automatic test_free_run();
    int pulses;
    bit prev;
    apply_reset();
    pulses = 0;
    prev = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(1, 0, 0);
      checks++;
      if ({ctrl_en, pulse_count} !== {m_en, 8'(m_cnt)}) begin
        errors++;
        $display("FAIL free_model c%0d: got %b %0d want %b %0d",
                 i, ctrl_en, pulse_count, m_en, m_cnt);
      end
      checks++;
      if (prev && ctrl_en === 1'b1) begin
        errors++;
        $display("FAIL free_adjacent c%0d: got two pulses want one", i);
      end
      if (ctrl_en === 1'b1) pulses++;
      prev = (ctrl_en === 1'b1);
    end
    checks++;
    if (pulses < 9 || pulses > 11) begin
      errors++;
      $display("FAIL free_pulses: got %0d want 9..11", pulses);
    end
  endtask

  task automatic test_random();
    bit rm, sb;
    apply_reset();
    rm = 0;
    sb = 0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 7) == 0) sb = ~sb;
      if ($urandom_range(0, 59) == 0) rm = ~rm;
      cycle(rm, sb, 0);
      checks++;
      if ({ctrl_en, halted, pulse_count} !== {m_en, m_halted, 8'(m_cnt)}) begin
        errors++;
        $display("FAIL random_model c%0d: got %b %b %0d want %b %b %0d",
                 i, ctrl_en, halted, pulse_count, m_en, m_halted, m_cnt);
      end
    end
  endtask

  task automatic test_halt_wrap();
    bit found;
    apply_reset();
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      cycle(1, 0, 0);
      if (m_mode && m_k >= R && ((m_k + 1) % R) == 0) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL halt_setup: got no wrap point want one within 60 cycles");
    end
    cycle(1, 0, 1);
    checks++;
    if ({ctrl_en, halted} !== 2'b01) begin
      errors++;
      $display("FAIL halt_wrap: got en=%b h=%b want en=0 h=1", ctrl_en, halted);
    end
    for (int i = 0; i < 60; i++) begin
      cycle((i / 10) % 2 == 1, (i % 12) < 7, 0);
      checks++;
      if ({ctrl_en, halted, pulse_count} !== {m_en, m_halted, 8'(m_cnt)}
          || ctrl_en !== 1'b0) begin
        errors++;
        $display("FAIL halted_quiet c%0d: got %b %b %0d want 0 1 %0d",
                 i, ctrl_en, halted, pulse_count, m_cnt);
      end
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    apply_reset();
    for (int i = 0; i < 12; i++) cycle(0, 1, 0);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0);
    cycle(0, 0, 1);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0);
    step_btn = 1'b1;
    @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    checks++;
    if ({ctrl_en, halted, pulse_count} !== 10'd0) begin
      errors++;
      $display("FAIL async_reset: got %b %b %0d want 0 0 0",
               ctrl_en, halted, pulse_count);
    end
    @(negedge CLK);
    step_btn = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      cycle(0, 0, 0);
      if (ctrl_en === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL reset_debounce_drop: got %0d pulses want 0", pulses);
    end
    for (int i = 0; i < 10; i++) cycle(1, 0, 0);
    @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    checks++;
    if ({ctrl_en, halted, pulse_count} !== 10'd0) begin
      errors++;
      $display("FAIL async_reset_div: got %b %b %0d want 0 0 0",
               ctrl_en, halted, pulse_count);
    end
    @(negedge CLK);
    run_mode = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      cycle(0, 0, 0);
      if (ctrl_en === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL reset_divider_drop: got %0d pulses want 0", pulses);
    end
  endtask

  task automatic test_wrap();
    int seen;
    bit wrapped;
    logic [7:0] prev;
    apply_reset();
    seen = 0;
    wrapped = 0;
    prev = 8'd0;
    run_f = 1'b1;
    for (int i = 0; i < 400 && seen < 300; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (ctrl_en_f === 1'b1) seen++;
      if (prev == 8'd255 && pulse_count_f == 8'd0) wrapped = 1;
      prev = pulse_count_f;
      if (seen == 300) halt_f = 1'b1;
    end
    repeat (3) @(negedge CLK);
    checks++;
    if (seen !== 300) begin
      errors++;
      $display("FAIL wrap_timeout: got %0d pulses want 300", seen);
    end
    checks++;
    if (pulse_count_f !== 8'(seen % 256)) begin
      errors++;
      $display("FAIL wrap_count: got %0d want %0d", pulse_count_f, seen % 256);
    end
    checks++;
    if (!wrapped) begin
      errors++;
      $display("FAIL wrap_seen: got no 255->0 step want one");
    end
    checks++;
    if ({ctrl_en_f, halted_f} !== 2'b01) begin
      errors++;
      $display("FAIL wrap_halt: got en=%b h=%b want 0 1", ctrl_en_f, halted_f);
    end
    halt_f = 1'b0;
    run_f = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_step_latency();
    test_bounce();
    test_free_run();
    test_random();
    test_halt_wrap();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
